// File: rtl/mem_stage_if.sv
// mem_stage_if: groups the execute->memory handshake, the memory-side
// inputs (SRAM read data, mul/div results, flushes) and the memory->
// writeback / decode / execute outputs of the memory-access stage.
// The slave modport is the stage itself; the master modport is whoever
// surrounds it (pipeline neighbours or a testbench).
interface mem_stage_if;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [135:0] es_to_ms_bus;
  logic [31:0]  data_sram_rdata;
  logic [63:0]  mul_result;
  logic [31:0]  div_quotient;
  logic [31:0]  div_remainder;
  logic         excp_flush;
  logic         ertn_flush;
  logic         ms_to_ws_valid;
  logic [127:0] ms_to_ws_bus;
  logic [38:0]  ms_to_ds_forward_bus;
  logic         ms_to_ds_valid;
  logic         ms_to_es_excp;

  modport master (
    output ws_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_rdata,
           mul_result, div_quotient, div_remainder, excp_flush, ertn_flush,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_forward_bus,
           ms_to_ds_valid, ms_to_es_excp
  );

  modport slave (
    input  ws_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_rdata,
           mul_result, div_quotient, div_remainder, excp_flush, ertn_flush,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_forward_bus,
           ms_to_ds_valid, ms_to_es_excp
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage pipeline. Registers the
// execute->memory bus, aligns/extends load data from the synchronous data
// SRAM, selects mul/div results and drives the writeback, forwarding and
// exception-hint buses.
// Optional feature macro: MS_RDATA_HOLD_EN -- when defined, the SRAM read
// data seen in the first resident cycle is captured so that a stalled load
// keeps returning it even if execute re-reads the SRAM. Without it the
// SRAM data feeds alignment directly (only safe when ws_allowin is tied 1).
module mem_stage (
  input  logic       clk,
  input  logic       resetn,
  mem_stage_if.slave ms_if
);

  logic         ms_valid;
  logic [135:0] bus_r;
  logic         ms_ready_go;
  logic         flush;

  // Decoded fields of the registered execute->memory bus
  logic         mem_sign_exted;
  logic [8:0]   excp_num;
  logic         csr_we;
  logic [13:0]  csr_idx;
  logic [31:0]  csr_result;
  logic         ertn;
  logic         excp;
  logic [1:0]   mem_size;
  logic [3:0]   mul_div_op;
  logic         load_op;
  logic         gr_we;
  logic [4:0]   dest;
  logic [31:0]  result;
  logic [31:0]  pc;
  logic [1:0]   off;

  logic [31:0]  load_rdata;
  logic [7:0]   ld_byte;
  logic [15:0]  ld_half;
  logic [31:0]  load_data;
  logic [31:0]  final_result;
  logic         forward_enable;

  assign mem_sign_exted = bus_r[135];
  assign excp_num       = bus_r[134:126];
  assign csr_we         = bus_r[125];
  assign csr_idx        = bus_r[124:111];
  assign csr_result     = bus_r[110:79];
  assign ertn           = bus_r[78];
  assign excp           = bus_r[77];
  assign mem_size       = bus_r[76:75];
  assign mul_div_op     = bus_r[74:71];
  assign load_op        = bus_r[70];
  assign gr_we          = bus_r[69];
  assign dest           = bus_r[68:64];
  assign result         = bus_r[63:32];
  assign pc             = bus_r[31:0];
  assign off            = result[1:0];

  // Everything completes in one cycle here, so the stage is never the stall source
  assign ms_ready_go    = 1'b1;
  assign flush          = ms_if.excp_flush | ms_if.ertn_flush;
  assign ms_if.ms_allowin     = !ms_valid | (ms_ready_go & ms_if.ws_allowin);
  assign ms_if.ms_to_ws_valid = ms_valid & ms_ready_go;
  assign ms_if.ms_to_ds_valid = ms_valid;
  assign ms_if.ms_to_es_excp  = ms_valid & (excp | ertn);

  // Pipeline register: a flush empties the stage and leaves bus_r untouched
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid <= 1'b0;
      bus_r    <= '0;
    end else if (flush) begin
      ms_valid <= 1'b0;
    end else if (ms_if.ms_allowin) begin
      ms_valid <= ms_if.es_to_ms_valid;
      bus_r    <= ms_if.es_to_ms_bus;
    end
  end

`ifdef MS_RDATA_HOLD_EN
  logic [31:0] rdata_q;
  logic        hold_vld;

  // Capture the SRAM data on the first resident cycle that does not hand off
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q  <= '0;
      hold_vld <= 1'b0;
    end else if (flush || ms_if.ms_allowin) begin
      hold_vld <= 1'b0;
    end else if (!hold_vld) begin
      rdata_q  <= ms_if.data_sram_rdata;
      hold_vld <= 1'b1;
    end
  end

  assign load_rdata = hold_vld ? rdata_q : ms_if.data_sram_rdata;
`else
  assign load_rdata = ms_if.data_sram_rdata;
`endif

  // Load alignment and sign/zero extension; misaligned halfwords read as 0
  always_comb begin
    ld_byte   = load_rdata[{off, 3'b000} +: 8];
    ld_half   = off[1] ? load_rdata[31:16] : load_rdata[15:0];
    load_data = load_rdata;
    if (mem_size[0]) begin
      load_data = {{24{mem_sign_exted & ld_byte[7]}}, ld_byte};
    end else if (mem_size[1]) begin
      if (off[0]) begin
        load_data = 32'h0;
      end else begin
        load_data = {{16{mem_sign_exted & ld_half[15]}}, ld_half};
      end
    end
  end

  // Result select: mul/div units win, otherwise load data or the ALU result
  always_comb begin
    case (mul_div_op)
      4'b0001: final_result = ms_if.mul_result[31:0];
      4'b0010: final_result = ms_if.mul_result[63:32];
      4'b0100: final_result = ms_if.div_quotient;
      4'b1000: final_result = ms_if.div_remainder;
      default: final_result = load_op ? load_data : result;
    endcase
  end

  assign forward_enable = ms_valid & gr_we & (dest != 5'd0);

  assign ms_if.ms_to_ws_bus = {excp_num, csr_we, csr_idx, csr_result,
                               ertn, excp, gr_we, dest, final_result, pc};

  // Forwarded value is masked when nothing is forwarded so decode sees zeros
  assign ms_if.ms_to_ds_forward_bus = {1'b0, forward_enable, dest,
                                       forward_enable ? final_result : 32'h0};

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage with a transaction-level
// reference model and a per-cycle compare process.
module tb_mem_stage;

`ifdef MS_RDATA_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic clk;
  logic resetn;
  mem_stage_if ms_if();

  mem_stage dut (
    .clk    (clk),
    .resetn (resetn),
    .ms_if  (ms_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Instruction resident in the stage, how many cycles it has stalled there,
  // and the SRAM data it saw on its first cycle.
  logic         m_valid;
  logic [135:0] m_bus;
  int           m_age;
  logic [31:0]  m_first_rd;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_valid    <= 1'b0;
      m_bus      <= '0;
      m_age      <= 0;
      m_first_rd <= '0;
    end else if (ms_if.excp_flush || ms_if.ertn_flush) begin
      m_valid <= 1'b0;
      m_age   <= 0;
    end else if (!m_valid || ms_if.ws_allowin) begin
      m_valid <= ms_if.es_to_ms_valid;
      m_bus   <= ms_if.es_to_ms_bus;
      m_age   <= 0;
    end else begin
      if (m_age == 0) m_first_rd <= ms_if.data_sram_rdata;
      m_age <= m_age + 1;
    end
  end

  function automatic logic [31:0] exp_final(input logic [135:0] b, input logic [31:0] rd,
                                            input logic [63:0] mul, input logic [31:0] q,
                                            input logic [31:0] r);
    int          off = int'(b[33:32]);
    logic [31:0] v;
    case (b[74:71])
      4'd1: return mul[31:0];
      4'd2: return mul[63:32];
      4'd4: return q;
      4'd8: return r;
      default: ;
    endcase
    if (!b[70]) return b[63:32];
    if (b[75]) begin
      v = (rd >> (8 * off)) & 32'hFF;
      if (b[135] && v[7]) v = v | 32'hFFFF_FF00;
      return v;
    end
    if (b[76]) begin
      if (off == 0)      v = rd & 32'hFFFF;
      else if (off == 2) v = rd >> 16;
      else return 32'h0;
      if (b[135] && v[15]) v = v | 32'hFFFF_0000;
      return v;
    end
    return rd;
  endfunction

  // Compare process: outputs checked against the model every cycle
  always @(negedge clk) begin
    logic [31:0]  rd_eff;
    logic [31:0]  fin;
    logic         fe;
    logic [127:0] ws_exp;
    rd_eff = (HOLD && m_age > 0) ? m_first_rd : ms_if.data_sram_rdata;
    fin    = exp_final(m_bus, rd_eff, ms_if.mul_result, ms_if.div_quotient, ms_if.div_remainder);
    fe     = m_valid && m_bus[69] && (m_bus[68:64] != 0);
    ws_exp = {m_bus[134:126], m_bus[125], m_bus[124:111], m_bus[110:79],
              m_bus[78], m_bus[77], m_bus[69], m_bus[68:64], fin, m_bus[31:0]};
    check("m_allowin", 128'(ms_if.ms_allowin), 128'(!m_valid || ms_if.ws_allowin));
    check("m_ws_valid", 128'(ms_if.ms_to_ws_valid), 128'(m_valid));
    check("m_ds_valid", 128'(ms_if.ms_to_ds_valid), 128'(m_valid));
    check("m_es_excp", 128'(ms_if.ms_to_es_excp), 128'(m_valid && (m_bus[77] || m_bus[78])));
    check("m_fwd_en", 128'(ms_if.ms_to_ds_forward_bus[37]), 128'(fe));
    if (m_valid || !resetn) begin
      check("m_ws_bus", ms_if.ms_to_ws_bus, ws_exp);
      check("m_fwd_bus", 128'(ms_if.ms_to_ds_forward_bus),
            128'({1'b0, fe, m_bus[68:64], fe ? fin : 32'h0}));
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [135:0] mk(input logic sx, input logic [1:0] size, input logic [3:0] op,
                                      input logic ld, input logic [4:0] dest,
                                      input logic [31:0] res, input logic [31:0] pc);
    logic [135:0] b;
    b          = '0;
    b[135]     = sx;
    b[76:75]   = size;
    b[74:71]   = op;
    b[70]      = ld;
    b[69]      = 1'b1;
    b[68:64]   = dest;
    b[63:32]   = res;
    b[31:0]    = pc;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [135:0] b);
    ms_if.es_to_ms_valid = 1'b1;
    ms_if.es_to_ms_bus   = b;
    tick();
    ms_if.es_to_ms_valid = 1'b0;
  endtask

  task automatic load_case(input string name, input logic [135:0] b,
                           input logic [31:0] rd, input logic [31:0] exp);
    accept(b);
    ms_if.data_sram_rdata = rd;
    #1;
    check(name, 128'(ms_if.ms_to_ws_bus[63:32]), 128'(exp));
    $display("txn %s: rdata=%h final_result=%h", name, rd, ms_if.ms_to_ws_bus[63:32]);
  endtask

  initial begin
    logic [135:0] b;
    logic [31:0]  stall_exp;
    logic [3:0]   ops [5];
    ops = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd8};

    resetn                = 1'b0;
    ms_if.ws_allowin      = 1'b1;
    ms_if.es_to_ms_valid  = 1'b0;
    ms_if.es_to_ms_bus    = '0;
    ms_if.data_sram_rdata = 32'h0;
    ms_if.mul_result      = 64'h0;
    ms_if.div_quotient    = 32'h0;
    ms_if.div_remainder   = 32'h0;
    ms_if.excp_flush      = 1'b0;
    ms_if.ertn_flush      = 1'b0;
    #2;
    check("rst_allowin", 128'(ms_if.ms_allowin), 128'(1));
    check("rst_ws_valid", 128'(ms_if.ms_to_ws_valid), 128'(0));
    check("rst_ws_bus", ms_if.ms_to_ws_bus, 128'(0));
    check("rst_fwd_bus", 128'(ms_if.ms_to_ds_forward_bus), 128'(0));
    $display("txn reset: allowin=%b ws_valid=%b", ms_if.ms_allowin, ms_if.ms_to_ws_valid);
    tick();
    tick();
    resetn = 1'b1;
    tick();

    // Load alignment vectors
    load_case("ldb_sx",   mk(1, 2'b01, 0, 1, 3, 32'h1003, 32'h100), 32'h80FF_1234, 32'hFFFF_FF80);
    load_case("ldb_zx",   mk(0, 2'b01, 0, 1, 3, 32'h1003, 32'h104), 32'h80FF_1234, 32'h0000_0080);
    load_case("ldb_off0", mk(1, 2'b01, 0, 1, 3, 32'h1000, 32'h108), 32'h80FF_1234, 32'h0000_0034);
    load_case("ldh_sx",   mk(1, 2'b10, 0, 1, 4, 32'h2002, 32'h10C), 32'h8001_7FFF, 32'hFFFF_8001);
    load_case("ldh_zx",   mk(0, 2'b10, 0, 1, 4, 32'h2000, 32'h110), 32'h8001_8FFF, 32'h0000_8FFF);
    load_case("ldh_mis",  mk(1, 2'b10, 0, 1, 4, 32'h2001, 32'h114), 32'h8001_7FFF, 32'h0000_0000);
    load_case("ldw",      mk(0, 2'b00, 0, 1, 6, 32'h3000, 32'h118), 32'h8001_7FFF, 32'h8001_7FFF);

    // Mul/div selection and forwarding
    ms_if.mul_result    = 64'h1234_5678_9ABC_DEF0;
    ms_if.div_quotient  = 32'h0000_0007;
    ms_if.div_remainder = 32'h0000_0003;
    accept(mk(0, 0, 4'b0010, 0, 5, 32'hAAAA_AAAA, 32'h120));
    #1;
    check("mulh", 128'(ms_if.ms_to_ws_bus[63:32]), 128'(32'h1234_5678));
    check("fwd_d5", 128'(ms_if.ms_to_ds_forward_bus), 128'({1'b0, 1'b1, 5'd5, 32'h1234_5678}));
    $display("txn mulh: fwd=%h", ms_if.ms_to_ds_forward_bus);
    accept(mk(0, 0, 4'b0010, 0, 0, 32'hAAAA_AAAA, 32'h124));
    #1;
    check("fwd_d0", 128'(ms_if.ms_to_ds_forward_bus), 128'(0));
    $display("txn mulh_d0: fwd=%h", ms_if.ms_to_ds_forward_bus);
    load_case("mull", mk(0, 0, 4'b0001, 0, 7, 32'h1, 32'h128), 32'h0, 32'h9ABC_DEF0);
    load_case("divq", mk(0, 0, 4'b0100, 0, 7, 32'h1, 32'h12C), 32'h0, 32'h0000_0007);
    load_case("divr", mk(0, 0, 4'b1000, 1, 7, 32'h1, 32'h130), 32'h0, 32'h0000_0003);

    // Stalled load: rdata changes after the first cycle
    tick();
    ms_if.ws_allowin = 1'b0;
    accept(mk(0, 2'b00, 0, 1, 9, 32'h4000, 32'h200));
    ms_if.data_sram_rdata = 32'h1122_3344;
    ms_if.es_to_ms_valid  = 1'b1;
    ms_if.es_to_ms_bus    = mk(0, 0, 0, 0, 10, 32'h5555, 32'h204);
    #1;
    check("stall_allowin0", 128'(ms_if.ms_allowin), 128'(0));
    check("stall_first", 128'(ms_if.ms_to_ws_bus[63:32]), 128'(32'h1122_3344));
    stall_exp = HOLD ? 32'h1122_3344 : 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      tick();
      ms_if.data_sram_rdata = 32'hDEAD_BEEF;
      #1;
      check("stall_allowin", 128'(ms_if.ms_allowin), 128'(0));
      check("stall_data", 128'(ms_if.ms_to_ws_bus[63:32]), 128'(stall_exp));
      $display("txn stall%0d: final_result=%h", i, ms_if.ms_to_ws_bus[63:32]);
    end
    tick();
    ms_if.es_to_ms_valid = 1'b0;
    ms_if.ws_allowin     = 1'b1;
    #1;
    check("stall_release", 128'(ms_if.ms_to_ws_valid), 128'(1));
    check("stall_rel_data", 128'(ms_if.ms_to_ws_bus[63:32]), 128'(stall_exp));
    check("stall_rel_pc", 128'(ms_if.ms_to_ws_bus[31:0]), 128'(32'h200));
    tick();
    check("stall_empty", 128'(ms_if.ms_to_ws_valid), 128'(0));
    $display("txn stall_done: ws_valid=%b", ms_if.ms_to_ws_valid);

    // Exception hint and flush
    b = mk(0, 0, 0, 0, 8, 32'h77, 32'h300);
    b[134:126] = 9'h1AB;
    b[125]     = 1'b1;
    b[124:111] = 14'h2C5;
    b[110:79]  = 32'hC0DE_0001;
    b[77]      = 1'b1;
    accept(b);
    #1;
    check("excp_hint", 128'(ms_if.ms_to_es_excp), 128'(1));
    check("excp_fields", 128'(ms_if.ms_to_ws_bus[127:70]),
          128'({9'h1AB, 1'b1, 14'h2C5, 32'hC0DE_0001, 1'b0, 1'b1}));
    ms_if.excp_flush     = 1'b1;
    ms_if.es_to_ms_valid = 1'b1;
    ms_if.es_to_ms_bus   = mk(0, 0, 0, 0, 9, 32'h99, 32'h304);
    #1;
    check("flush_xfer", 128'(ms_if.ms_to_ws_valid), 128'(1));
    tick();
    ms_if.excp_flush     = 1'b0;
    ms_if.es_to_ms_valid = 1'b0;
    #1;
    check("flush_empty", 128'(ms_if.ms_to_ws_valid), 128'(0));
    check("flush_no_cap", 128'(ms_if.ms_to_ws_bus[31:0]), 128'(32'h300));
    $display("txn excp_flush: ws_valid=%b pc=%h", ms_if.ms_to_ws_valid, ms_if.ms_to_ws_bus[31:0]);
    b = mk(0, 0, 0, 0, 8, 32'h78, 32'h308);
    b[78] = 1'b1;
    accept(b);
    #1;
    check("ertn_hint", 128'(ms_if.ms_to_es_excp), 128'(1));
    ms_if.ertn_flush = 1'b1;
    tick();
    ms_if.ertn_flush = 1'b0;
    #1;
    check("ertn_empty", 128'(ms_if.ms_to_ws_valid), 128'(0));

    // Reset asserted between edges in the middle of a stall
    ms_if.ws_allowin = 1'b0;
    accept(mk(1, 2'b01, 0, 1, 12, 32'h6001, 32'h400));
    ms_if.data_sram_rdata = 32'h0000_AA00;
    tick();
    check("mid_stall_valid", 128'(ms_if.ms_to_ws_valid), 128'(1));
    #2;
    resetn = 1'b0;
    #1;
    check("mid_rst_valid", 128'(ms_if.ms_to_ws_valid), 128'(0));
    check("mid_rst_allowin", 128'(ms_if.ms_allowin), 128'(1));
    check("mid_rst_bus", ms_if.ms_to_ws_bus, 128'(0));
    check("mid_rst_fwd", 128'(ms_if.ms_to_ds_forward_bus), 128'(0));
    $display("txn mid_reset: ws_valid=%b allowin=%b", ms_if.ms_to_ws_valid, ms_if.ms_allowin);
    tick();
    resetn = 1'b1;
    ms_if.ws_allowin = 1'b1;
    tick();
    load_case("post_rst_ldw", mk(0, 2'b00, 0, 1, 12, 32'h6000, 32'h404), 32'h0BAD_F00D, 32'h0BAD_F00D);

    // Mixed traffic with backpressure, checked by the model each cycle
    for (int i = 0; i < 40; i++) begin
      b = mk($urandom_range(0, 1), 2'($urandom_range(0, 2)), ops[$urandom_range(0, 4)],
             $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom, $urandom);
      b[134:79] = {$urandom, $urandom};
      b[77]     = ($urandom_range(0, 7) == 0);
      ms_if.es_to_ms_valid  = $urandom_range(0, 1);
      ms_if.es_to_ms_bus    = b;
      ms_if.ws_allowin      = ($urandom_range(0, 3) != 0);
      ms_if.data_sram_rdata = $urandom;
      ms_if.mul_result      = {$urandom, $urandom};
      ms_if.div_quotient    = $urandom;
      ms_if.div_remainder   = $urandom;
      ms_if.excp_flush      = ($urandom_range(0, 15) == 0);
      tick();
      $display("txn mix%0d: ws_valid=%b pc=%h result=%h", i, ms_if.ms_to_ws_valid,
               ms_if.ms_to_ws_bus[31:0], ms_if.ms_to_ws_bus[63:32]);
    end
    ms_if.excp_flush     = 1'b0;
    ms_if.es_to_ms_valid = 1'b0;
    ms_if.ws_allowin     = 1'b1;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
